// File: rtl/equiv_stim_gen.sv
// equiv_stim_gen: LFSR-driven bounded stimulus source (wire0..wire3) with start/busy/done handshake
// Ports: clk, rst (async, active-high), start, hold, seed_load, seed_in[63:0] in;
//        wire0[3:0], wire1[20:0], wire2[16:0], wire3[21:0], valid, busy, done, vec_count[15:0] out.
// Optional feature: define EQUIV_STIM_CORNER_EN to prefix each run with 4 corner vectors.
module equiv_stim_gen #(
  parameter int          NUM_VECTORS = 256,
  parameter logic [63:0] SEED        = 64'h0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  input  logic        seed_load,
  input  logic [63:0] seed_in,
  output logic [3:0]  wire0,
  output logic [20:0] wire1,
  output logic [16:0] wire2,
  output logic [21:0] wire3,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] vec_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);
  state_t      state, state_d;
  logic [63:0] lfsr, lfsr_d, out_q, out_d, vec;
  logic        valid_d, busy_d, done_d, adv, fb;
  logic [15:0] cnt_d;
  assign fb = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];
  assign wire0 = out_q[3:0];
  assign wire1 = out_q[24:4];
  assign wire2 = out_q[41:25];
  assign wire3 = out_q[63:42];
`ifdef EQUIV_STIM_CORNER_EN
  // MSB of every field; corner patterns are 0, all-ones, MSB-only (min), ~MSB (max)
  localparam logic [63:0] MSB_MASK = 64'h8000_0200_0100_0008;
  logic corner;
  assign corner = vec_count < 16'd4;
  assign adv = !corner;
  assign vec = !corner ? lfsr :
               vec_count[1] ? (vec_count[0] ? ~MSB_MASK : MSB_MASK) : {64{vec_count[0]}};
`else
  assign adv = 1'b1;
  assign vec = lfsr;
`endif
  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    out_d   = out_q;
    valid_d = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = vec_count;
    unique case (state)
      IDLE: begin
        // a load in the same cycle as start lands first, so the run begins from it
        if (seed_load) lfsr_d = (seed_in == 64'd0) ? SEED : seed_in;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = 16'd0;
        end
      end
      RUN: if (!hold) begin
        out_d   = vec;
        valid_d = 1'b1;
        if (adv) lfsr_d = {lfsr[62:0], fb};
        cnt_d   = (&vec_count) ? vec_count : vec_count + 16'd1;
        if (vec_count == LAST) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      out_q     <= 64'd0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_count <= 16'd0;
    end else begin
      state     <= state_d;
      lfsr      <= lfsr_d;
      out_q     <= out_d;
      valid     <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      vec_count <= cnt_d;
    end
  end
endmodule

// File: tb/tb_equiv_stim_gen.sv
// tb_equiv_stim_gen: directed self-checking bench for equiv_stim_gen (NUM_VECTORS=5, SEED=1)
module tb_equiv_stim_gen;
  localparam int          NV   = 5;
  localparam logic [63:0] SEED = 64'h1;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0, seed_load = 1'b0;
  logic [63:0] seed_in = 64'd0;
  logic [3:0]  wire0;
  logic [20:0] wire1;
  logic [16:0] wire2;
  logic [21:0] wire3;
  logic        valid, busy, done;
  logic [15:0] vec_count;
  logic [63:0] m;
  int          errors = 0, checks = 0;
  equiv_stim_gen #(.NUM_VECTORS(NV), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .seed_load(seed_load), .seed_in(seed_in),
    .wire0(wire0), .wire1(wire1), .wire2(wire2), .wire3(wire3),
    .valid(valid), .busy(busy), .done(done), .vec_count(vec_count)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] nxt(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_vec"}, {wire3, wire2, wire1, wire0}, 64'd0);
    chk({tag, "_flags"}, {61'd0, valid, busy, done}, 64'd0);
    chk({tag, "_cnt"}, {48'd0, vec_count}, 64'd0);
  endtask
  // one full run; m holds the model LFSR state and continues across runs
  task automatic run(input int hold_at, input bit restart, input bit ld, input logic [63:0] sd);
    start = 1'b1;
    seed_load = ld;
    seed_in = sd;
    if (ld) m = (sd == 64'd0) ? SEED : sd;
    tick;
    start = 1'b0;
    seed_load = 1'b0;
    chk("start_busy", {62'd0, busy, valid}, 64'h2);
    for (int i = 0; i < NV; i++) begin
      if (i == hold_at) begin
        hold = 1'b1;
        repeat (3) begin
          tick;
          chk("hold_valid", {63'd0, valid}, 64'd0);
          chk("hold_cnt", {48'd0, vec_count}, 64'(i));
        end
        hold = 1'b0;
      end
      if (restart && i == 2) start = 1'b1;
      tick;
      start = 1'b0;
      chk("vec_valid", {62'd0, valid, done}, 64'h2);
      chk("vec_data", {wire3, wire2, wire1, wire0}, m);
      chk("vec_cnt", {48'd0, vec_count}, 64'(i + 1));
      m = nxt(m);
    end
    tick;
    chk("done_pulse", {61'd0, done, busy, valid}, 64'h4);
    chk("done_cnt", {48'd0, vec_count}, 64'(NV));
    tick;
    chk("done_end", {61'd0, done, busy, valid}, 64'h0);
  endtask
  initial begin
    m = SEED;
    #12;
    chk_idle_zero("reset");
    rst = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("first_busy", {62'd0, busy, valid}, 64'h2);
    for (int i = 0; i < NV; i++) begin
      tick;
      chk("seed1_w0", {60'd0, wire0}, (i < 4) ? 64'(1 << i) : 64'd0);
      chk("seed1_w1", {43'd0, wire1}, (i == 4) ? 64'd1 : 64'd0);
      chk("seed1_w23", {25'd0, wire3, wire2}, 64'd0);
    end
    tick;
    chk("seed1_done", {61'd0, done, busy, valid}, 64'h4);
    chk("seed1_cnt", {48'd0, vec_count}, 64'd5);
    tick;
    m = 64'h20;
    run(2, 1'b0, 1'b0, 64'd0);
    seed_load = 1'b1;
    seed_in = 64'd0;
    tick;
    seed_load = 1'b0;
    m = SEED;
    run(-1, 1'b1, 1'b0, 64'd0);
    run(-1, 1'b0, 1'b1, 64'hF00D_CAFE_DEAD_BEEF);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    #2 rst = 1'b1;
    #1;
    chk_idle_zero("async_rst");
    tick;
    chk("rst_no_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    tick;
    chk("rst_idle", {62'd0, busy, valid}, 64'd0);
    m = SEED;
    run(0, 1'b0, 1'b0, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
